uart_tx: RTL and testbench

Transmit half of a 16550-style UART. It pulls one character from the transmit holding FIFO when the FIFO is not empty. It serialises the character LSB-first onto `tx` as start bit, 5–8 data bits, optional parity and 1/1.5/2 stop bits, with each bit lasting 16 ticks of the 16x baud strobe. Line-control fields come from the LCR; FIFO handshake goes to the THR/FIFO block.

---
 rtl/uart_tx.sv | 151 +++++++++++++++
 tb/tb_uart_tx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Transmit half of a 16550-style UART: pulls characters from the holding FIFO and
// serialises start, 5-8 data bits LSB-first, optional parity and stop bits at 16 ticks per bit.
module uart_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       thre,
  input  logic       set_break,
  input  logic       sticky_parity,
  input  logic       eps,
  input  logic       pen,
  input  logic       stb,
  input  logic [1:0] wls,
  input  logic [7:0] din,
  output logic       pop,
  output logic       sreg_empty,
  output logic       tx
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state, state_nx;
  logic [4:0]  tick, tick_nx;
  logic [2:0]  idx, idx_nx;
  logic [7:0]  shreg, shreg_nx;
  logic [1:0]  f_wls, f_wls_nx;
  logic        f_pen, f_pen_nx;
  logic        f_eps, f_eps_nx;
  logic        f_sp, f_sp_nx;
  logic        f_stb, f_stb_nx;
  logic        pop_nx;

  logic [7:0]  data_mask;
  logic        data_xor;
  logic        parity_bit;
  logic [2:0]  last_idx;
  logic [4:0]  stop_last;
  logic        line;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      tick  <= '0;
      idx   <= '0;
      shreg <= '0;
      f_wls <= '0;
      f_pen <= 1'b0;
      f_eps <= 1'b0;
      f_sp  <= 1'b0;
      f_stb <= 1'b0;
      pop   <= 1'b0;
    end else begin
      state <= state_nx;
      tick  <= tick_nx;
      idx   <= idx_nx;
      shreg <= shreg_nx;
      f_wls <= f_wls_nx;
      f_pen <= f_pen_nx;
      f_eps <= f_eps_nx;
      f_sp  <= f_sp_nx;
      f_stb <= f_stb_nx;
      pop   <= pop_nx;
    end
  end

  // Frame-local LCR copies decide word length, parity and stop length for the whole frame.
  always_comb begin
    data_mask  = 8'hFF >> (2'd3 - f_wls);
    data_xor   = ^(shreg & data_mask);
    parity_bit = f_sp ? ~f_eps : (f_eps ? data_xor : ~data_xor);
    last_idx   = {1'b0, f_wls} + 3'd4;
    if (!f_stb)              stop_last = 5'd15;
    else if (f_wls == 2'b00) stop_last = 5'd23;
    else                     stop_last = 5'd31;
  end

  always_comb begin
    state_nx = state;
    tick_nx  = tick;
    idx_nx   = idx;
    shreg_nx = shreg;
    f_wls_nx = f_wls;
    f_pen_nx = f_pen;
    f_eps_nx = f_eps;
    f_sp_nx  = f_sp;
    f_stb_nx = f_stb;
    pop_nx   = 1'b0;
    if (baud_pulse) begin
      tick_nx = tick + 5'd1;
      case (state)
        IDLE: begin
          tick_nx = '0;
          if (!thre) begin
            shreg_nx = din;
            f_wls_nx = wls;
            f_pen_nx = pen;
            f_eps_nx = eps;
            f_sp_nx  = sticky_parity;
            f_stb_nx = stb;
            pop_nx   = 1'b1;
            state_nx = START;
          end
        end
        START: begin
          if (tick == 5'd15) begin
            tick_nx  = '0;
            idx_nx   = '0;
            state_nx = DATA;
          end
        end
        DATA: begin
          if (tick == 5'd15) begin
            tick_nx = '0;
            if (idx == last_idx) state_nx = f_pen ? PARITY : STOP;
            else                 idx_nx   = idx + 3'd1;
          end
        end
        PARITY: begin
          if (tick == 5'd15) begin
            tick_nx  = '0;
            state_nx = STOP;
          end
        end
        STOP: begin
          if (tick == stop_last) begin
            tick_nx  = '0;
            state_nx = IDLE;
          end
        end
        default: begin
          tick_nx  = '0;
          state_nx = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    case (state)
      START:   line = 1'b0;
      DATA:    line = shreg[idx];
      PARITY:  line = parity_bit;
      default: line = 1'b1;
    endcase
  end

  // Break masks the line only; the frame keeps its timing underneath.
  assign tx         = line & ~set_break;
  assign sreg_empty = (state == IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frames, hand-written corner sequences
// and randomized frames compared tick-by-tick against a per-frame bit-list model.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_pulse = 1'b0;
  logic       thre = 1'b1;
  logic       set_break = 1'b0;
  logic       sticky_parity = 1'b0;
  logic       eps = 1'b0;
  logic       pen = 1'b0;
  logic       stb = 1'b0;
  logic [1:0] wls = 2'b00;
  logic [7:0] din = 8'h00;
  logic       pop;
  logic       sreg_empty;
  logic       tx;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] din;
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       sp;
    logic       stb;
  } cfg_t;

  typedef struct {
    cfg_t cfg;
    int   div;
    int   exp_ticks;
    logic exp_par;
  } vec_t;

  // {sreg_empty, tx} per baud tick, index 0 is the interval after the load edge
  logic [1:0] exp_q[$];
  logic [1:0] cap_q[$];
  logic       brk_q[$];
  int         pop_cnt = 0;
  logic       rec_on = 1'b0;
  logic       started = 1'b0;
  int         baud_div = 6;
  int         div_cnt = 0;

  // clock / reset block
  always #5 clk = ~clk;

  uart_tx dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .thre(thre),
    .set_break(set_break), .sticky_parity(sticky_parity), .eps(eps),
    .pen(pen), .stb(stb), .wls(wls), .din(din),
    .pop(pop), .sreg_empty(sreg_empty), .tx(tx)
  );

  // monitor: captures line state after every edge that carried a baud tick
  always @(posedge clk) begin
    logic bp_s, th_s;
    bp_s = baud_pulse;
    th_s = thre;
    #1;
    if (rec_on) begin
      if (pop) pop_cnt++;
      if (bp_s && (started || !th_s)) begin
        started = 1'b1;
        cap_q.push_back({sreg_empty, tx});
        brk_q.push_back(set_break);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk);
    div_cnt++;
    if (div_cnt >= baud_div) begin
      baud_pulse = 1'b1;
      div_cnt = 0;
    end else begin
      baud_pulse = 1'b0;
    end
  endtask

  task automatic apply_cfg(input cfg_t c);
    din = c.din;
    wls = c.wls;
    pen = c.pen;
    eps = c.eps;
    sticky_parity = c.sp;
    stb = c.stb;
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.din = 8'($urandom_range(0, 255));
    c.wls = 2'($urandom_range(0, 3));
    c.pen = 1'($urandom_range(0, 1));
    c.eps = 1'($urandom_range(0, 1));
    c.sp  = 1'($urandom_range(0, 1));
    c.stb = 1'($urandom_range(0, 1));
    return c;
  endfunction

  // reference model: frame described as a list of bit values, each held 16 ticks
  function automatic logic model_parity(input cfg_t c);
    int n;
    int ones;
    n = int'(c.wls) + 5;
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(c.din[i]);
    if (c.sp) return ~c.eps;
    return c.eps ? ((ones % 2) == 1) : ((ones % 2) == 0);
  endfunction

  task automatic model_push(input cfg_t c);
    logic bits[$];
    int   stop_ticks;
    bits.push_back(1'b0);
    for (int i = 0; i < int'(c.wls) + 5; i++) bits.push_back(c.din[i]);
    if (c.pen) bits.push_back(model_parity(c));
    foreach (bits[b]) for (int t = 0; t < 16; t++) exp_q.push_back({1'b0, bits[b]});
    stop_ticks = !c.stb ? 16 : (c.wls == 2'b00 ? 24 : 32);
    for (int t = 0; t < stop_ticks; t++) exp_q.push_back(2'b01);
    exp_q.push_back(2'b11);
  endtask

  task automatic run_frames(input cfg_t c0, input cfg_t c1, input int n,
                            input int brk_on, input int brk_off, input string tag);
    cfg_t cs[2];
    int   starts[2];
    int   total;
    int   k;
    int   cyc;
    int   nmis;
    int   first;
    logic [1:0] e;
    cs[0] = c0;
    cs[1] = c1;
    exp_q.delete();
    cap_q.delete();
    brk_q.delete();
    pop_cnt = 0;
    started = 1'b0;
    for (int i = 0; i < n; i++) begin
      starts[i] = exp_q.size();
      model_push(cs[i]);
    end
    total = exp_q.size();
    apply_cfg(cs[0]);
    rec_on = 1'b1;
    thre = 1'b0;
    k = 0;
    cyc = 0;
    while (cap_q.size() < total && cyc < 20000) begin
      step();
      cyc++;
      if (k < n && cap_q.size() > starts[k]) begin
        if (k + 1 < n) apply_cfg(cs[k + 1]);
        else begin
          thre = 1'b1;
          apply_cfg(rand_cfg());
        end
        k++;
      end
      if (brk_on >= 0 && cap_q.size() == brk_on && !set_break) begin
        set_break = 1'b1;
        #1;
        check({tag, " break_immediate"}, 32'(tx), 32'd0);
      end
      if (brk_off >= 0 && cap_q.size() >= brk_off) set_break = 1'b0;
    end
    rec_on = 1'b0;
    thre = 1'b1;
    set_break = 1'b0;
    check({tag, " captured_ticks"}, 32'(cap_q.size()), 32'(total));
    nmis = 0;
    first = -1;
    for (int i = 0; i < cap_q.size() && i < total; i++) begin
      e = exp_q[i];
      if (brk_q[i]) e[0] = 1'b0;
      if (cap_q[i] !== e) begin
        nmis++;
        if (first < 0) begin
          first = i;
          $display("  %s first diff at tick %0d: {sreg_empty,tx} got %b expected %b", tag, i, cap_q[i], e);
        end
      end
    end
    check({tag, " tick_mismatches"}, 32'(nmis), 32'd0);
    check({tag, " pop_pulses"}, 32'(pop_cnt), 32'(n));
  endtask

  vec_t vecs[5];

  initial begin
    int   bad;
    int   cyc;
    int   len;
    int   n;
    cfg_t c, c2;

    vecs[0] = '{cfg: '{din: 8'hA5, wls: 2'b11, pen: 1'b1, eps: 1'b1, sp: 1'b0, stb: 1'b1},
                div: 6, exp_ticks: 192, exp_par: 1'b0};
    vecs[1] = '{cfg: '{din: 8'h1F, wls: 2'b00, pen: 1'b0, eps: 1'b0, sp: 1'b0, stb: 1'b1},
                div: 3, exp_ticks: 120, exp_par: 1'b0};
    vecs[2] = '{cfg: '{din: 8'h03, wls: 2'b11, pen: 1'b1, eps: 1'b0, sp: 1'b0, stb: 1'b0},
                div: 2, exp_ticks: 176, exp_par: 1'b1};
    vecs[3] = '{cfg: '{din: 8'h03, wls: 2'b11, pen: 1'b1, eps: 1'b1, sp: 1'b1, stb: 1'b0},
                div: 1, exp_ticks: 176, exp_par: 1'b0};
    vecs[4] = '{cfg: '{din: 8'h03, wls: 2'b11, pen: 1'b1, eps: 1'b0, sp: 1'b1, stb: 1'b0},
                div: 4, exp_ticks: 176, exp_par: 1'b1};

    // reset state
    repeat (3) step();
    check("reset tx", 32'(tx), 32'd1);
    check("reset pop", 32'(pop), 32'd0);
    check("reset sreg_empty", 32'(sreg_empty), 32'd1);
    step();
    rst = 1'b1;
    repeat (4) step();

    // idle with empty FIFO
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      #1;
      if (tx !== 1'b1 || pop !== 1'b0 || sreg_empty !== 1'b1) bad++;
    end
    check("idle cycles_bad", 32'(bad), 32'd0);

    // table-driven frames
    foreach (vecs[v]) begin
      baud_div = vecs[v].div;
      run_frames(vecs[v].cfg, vecs[v].cfg, 1, -1, -1, $sformatf("vec%0d", v));
      len = -1;
      for (int i = 0; i < cap_q.size(); i++) if (cap_q[i][1] === 1'b1 && len < 0) len = i;
      check($sformatf("vec%0d frame_ticks", v), 32'(len), 32'(vecs[v].exp_ticks));
      if (vecs[v].cfg.pen) begin
        n = 16 * (int'(vecs[v].cfg.wls) + 6) + 8;
        check($sformatf("vec%0d parity_bit", v), 32'(cap_q.size() > n ? cap_q[n][0] : 1'bx),
              32'(vecs[v].exp_par));
      end
    end

    // break raised mid-frame, frame timing unchanged
    baud_div = 2;
    c = '{din: 8'h5A, wls: 2'b11, pen: 1'b0, eps: 1'b0, sp: 1'b0, stb: 1'b0};
    run_frames(c, c, 1, 40, 100, "break");

    // back-to-back frames with thre held low
    baud_div = 3;
    c  = '{din: 8'hC3, wls: 2'b10, pen: 1'b1, eps: 1'b1, sp: 1'b0, stb: 1'b0};
    c2 = '{din: 8'h96, wls: 2'b01, pen: 1'b0, eps: 1'b0, sp: 1'b0, stb: 1'b1};
    run_frames(c, c2, 2, -1, -1, "b2b");

    // reset in the middle of the data bits
    baud_div = 2;
    apply_cfg('{din: 8'hF0, wls: 2'b11, pen: 1'b0, eps: 1'b0, sp: 1'b0, stb: 1'b0});
    cap_q.delete();
    brk_q.delete();
    started = 1'b0;
    rec_on = 1'b1;
    thre = 1'b0;
    cyc = 0;
    while (cap_q.size() < 1 && cyc < 1000) begin step(); cyc++; end
    thre = 1'b1;
    while (cap_q.size() < 30 && cyc < 2000) begin step(); cyc++; end
    check("reset_mid reached_data", 32'(cap_q.size() >= 30), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("reset_mid tx", 32'(tx), 32'd1);
    check("reset_mid sreg_empty", 32'(sreg_empty), 32'd1);
    check("reset_mid pop", 32'(pop), 32'd0);
    rec_on = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    repeat (3) step();
    c = '{din: 8'h6B, wls: 2'b11, pen: 1'b1, eps: 1'b0, sp: 1'b0, stb: 1'b1};
    run_frames(c, c, 1, -1, -1, "after_reset");

    // randomized frames, including consecutive-cycle baud strobes
    for (int r = 0; r < 20; r++) begin
      baud_div = $urandom_range(1, 4);
      c  = rand_cfg();
      c2 = rand_cfg();
      run_frames(c, c2, $urandom_range(1, 2), -1, -1, $sformatf("rand%0d", r));
      repeat ($urandom_range(0, 10)) step();
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
